// File: rtl/instr_align_stage_if.sv
// Handshake bundle around the instruction align stage.
//   ifq_*  : instruction fetch queue head and pop request
//   out_*  : registered {instr, pc, rvc} towards decode with valid/ready
// The master modport is the align stage. The slave modport is its environment,
// which is the fetch queue plus decode.
interface instr_align_stage_if;
   logic [1:0]  ifq_avail;
   logic [31:0] ifq_data;
   logic        ifq_pop;
   logic        ifq_pop_16bit;
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_rvc;

   modport master (
      input  ifq_avail, ifq_data, out_rdy,
      output ifq_pop, ifq_pop_16bit, out_vld, out_instr, out_pc, out_rvc
   );

   modport slave (
      output ifq_avail, ifq_data, out_rdy,
      input  ifq_pop, ifq_pop_16bit, out_vld, out_instr, out_pc, out_rvc
   );
endinterface

// File: rtl/instr_align_stage.sv
// Instruction align stage (pipeline stage 0).
// The stage classifies the fetch queue head as RVC or 32-bit and pops the
// matching number of halfwords. It tracks the PC and presents a registered
// {instr, pc, rvc} to decode.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush_req     jump/redirect: drops the held instruction and reloads the PC
//   flush_pc      redirect target (bit 0 ignored)
//   bus           queue/decode handshake (instr_align_stage_if.master)
//   stall_cnt     saturating count of cycles where the slot was free but starved
module instr_align_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_req,
   input  logic [31:0]            flush_pc,
   instr_align_stage_if.master    bus,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [31:0] ResetPcAligned = {RESET_PC[31:1], 1'b0};

   logic                   out_vld_q,   out_vld_d;
   logic [31:0]            out_instr_q, out_instr_d;
   logic [31:0]            out_pc_q,    out_pc_d;
   logic                   out_rvc_q,   out_rvc_d;
   logic [31:0]            fetch_pc_q,  fetch_pc_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic slot_free;
   logic is_rvc;
   logic has_one;
   logic has_two;
   logic can_issue;
   logic fire16;
   logic fire32;
   logic fire;

   // An avail value of 3 is treated like 2, so bit 1 alone means "two halfwords".
   assign has_one   = (bus.ifq_avail != 2'd0);
   assign has_two   = bus.ifq_avail[1];
   assign is_rvc    = (bus.ifq_data[1:0] != 2'b11);
   assign slot_free = ~out_vld_q | bus.out_rdy;
   assign can_issue = ~rst & ~flush_req & slot_free;

   // A 32-bit head with only one halfword present waits in the queue.
   assign fire16 = can_issue & has_one & is_rvc;
   assign fire32 = can_issue & has_two & ~is_rvc;
   assign fire   = fire16 | fire32;

   assign bus.ifq_pop       = fire;
   assign bus.ifq_pop_16bit = is_rvc;

   always_comb begin
      out_vld_d   = out_vld_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      out_rvc_d   = out_rvc_q;
      fetch_pc_d  = fetch_pc_q;
      stall_cnt_d = stall_cnt_q;

      if (flush_req) begin
         // The out_rdy input is ignored here, so a held instruction is dropped.
         out_vld_d  = 1'b0;
         fetch_pc_d = {flush_pc[31:1], 1'b0};
      end else if (fire) begin
         out_vld_d   = 1'b1;
         out_instr_d = fire16 ? {16'h0000, bus.ifq_data[15:0]} : bus.ifq_data;
         out_rvc_d   = fire16;
         out_pc_d    = fetch_pc_q;
         fetch_pc_d  = fetch_pc_q + (fire16 ? 32'd2 : 32'd4);
      end else if (bus.out_rdy) begin
         out_vld_d = 1'b0;
      end

      if (can_issue && !fire && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q   <= 1'b0;
         out_instr_q <= 32'h0;
         out_pc_q    <= ResetPcAligned;
         out_rvc_q   <= 1'b0;
         fetch_pc_q  <= ResetPcAligned;
         stall_cnt_q <= '0;
      end else begin
         out_vld_q   <= out_vld_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_rvc_q   <= out_rvc_d;
         fetch_pc_q  <= fetch_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.out_vld   = out_vld_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.out_rvc   = out_rvc_q;
   assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_instr_align_stage.sv
// Directed bench for instr_align_stage. Inputs change 1 time unit after the rising edge.
// Combinational pop outputs are checked 1 unit after the inputs are driven.
// Registered outputs are checked after each edge.
module tb_instr_align_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_req;
   logic [31:0] flush_pc;
   logic [15:0] stall_cnt;

   logic        rst2;
   logic [3:0]  stall_cnt2;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   instr_align_stage_if bus ();
   instr_align_stage_if bus2 ();

   instr_align_stage #(
      .RESET_PC    (32'h0000_0100),
      .STALL_CNT_W (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush_req (flush_req),
      .flush_pc  (flush_pc),
      .bus       (bus.master),
      .stall_cnt (stall_cnt)
   );

   // Narrow counter instance so saturation is reachable in a few cycles.
   instr_align_stage #(
      .RESET_PC    (32'h0000_0000),
      .STALL_CNT_W (4)
   ) dut_sat (
      .clk       (clk),
      .rst       (rst2),
      .flush_req (1'b0),
      .flush_pc  (32'h0),
      .bus       (bus2.master),
      .stall_cnt (stall_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic [1:0] avail, input logic [31:0] data, input logic rdy);
      bus.ifq_avail = avail;
      bus.ifq_data  = data;
      bus.out_rdy   = rdy;
   endtask

   initial begin
      rst       = 1'b1;
      flush_req = 1'b0;
      flush_pc  = 32'h0;
      rst2      = 1'b1;
      bus2.ifq_avail = 2'd0;
      bus2.ifq_data  = 32'h0;
      bus2.out_rdy   = 1'b0;
      drive(2'd2, 32'h0001_4501, 1'b1);

      // Reset state
      step();
      step();
      settle();
      chk("rst_vld",   {31'h0, bus.out_vld}, 32'h0);
      chk("rst_pc",    bus.out_pc, 32'h0000_0100);
      chk("rst_instr", bus.out_instr, 32'h0);
      chk("rst_rvc",   {31'h0, bus.out_rvc}, 32'h0);
      chk("rst_stall", {16'h0, stall_cnt}, 32'h0);
      chk("rst_pop",   {31'h0, bus.ifq_pop}, 32'h0);

      // RVC fire from the reset PC
      rst = 1'b0;
      settle();
      chk("rvc_pop",   {31'h0, bus.ifq_pop}, 32'h1);
      chk("rvc_pop16", {31'h0, bus.ifq_pop_16bit}, 32'h1);
      step();
      chk("rvc_vld",   {31'h0, bus.out_vld}, 32'h1);
      chk("rvc_instr", bus.out_instr, 32'h0000_4501);
      chk("rvc_rvc",   {31'h0, bus.out_rvc}, 32'h1);
      chk("rvc_pc",    bus.out_pc, 32'h0000_0100);

      // 32-bit head with one halfword: wait three cycles
      drive(2'd1, 32'h0000_0093, 1'b1);
      settle();
      chk("wait_pop", {31'h0, bus.ifq_pop}, 32'h0);
      step();
      step();
      step();
      chk("wait_stall", {16'h0, stall_cnt}, 32'd3);
      chk("wait_vld",   {31'h0, bus.out_vld}, 32'h0);
      drive(2'd2, 32'h0010_0093, 1'b1);
      settle();
      chk("w32_pop",   {31'h0, bus.ifq_pop}, 32'h1);
      chk("w32_pop16", {31'h0, bus.ifq_pop_16bit}, 32'h0);
      step();
      chk("w32_instr", bus.out_instr, 32'h0010_0093);
      chk("w32_rvc",   {31'h0, bus.out_rvc}, 32'h0);
      chk("w32_pc",    bus.out_pc, 32'h0000_0102);

      // Backpressure for four cycles and then a back-to-back accept
      drive(2'd2, 32'h0000_4105, 1'b0);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("hold_pop", {31'h0, bus.ifq_pop}, 32'h0);
         step();
         chk("hold_vld",   {31'h0, bus.out_vld}, 32'h1);
         chk("hold_instr", bus.out_instr, 32'h0010_0093);
         chk("hold_pc",    bus.out_pc, 32'h0000_0102);
      end
      chk("hold_stall", {16'h0, stall_cnt}, 32'd3);
      bus.out_rdy = 1'b1;
      settle();
      chk("b2b_pop", {31'h0, bus.ifq_pop}, 32'h1);
      step();
      chk("b2b_instr", bus.out_instr, 32'h0000_4105);
      chk("b2b_pc",    bus.out_pc, 32'h0000_0106);

      // Flush while holding a valid instruction
      flush_req = 1'b1;
      flush_pc  = 32'h0000_2003;
      drive(2'd2, 32'h0000_0001, 1'b1);
      settle();
      chk("fl_pop", {31'h0, bus.ifq_pop}, 32'h0);
      step();
      chk("fl_vld", {31'h0, bus.out_vld}, 32'h0);
      flush_req = 1'b0;
      drive(2'd0, 32'h0, 1'b1);
      step();
      drive(2'd2, 32'h0000_0001, 1'b1);
      step();
      chk("fl_first_vld", {31'h0, bus.out_vld}, 32'h1);
      chk("fl_first_pc",  bus.out_pc, 32'h0000_2002);
      chk("fl_stall",     {16'h0, stall_cnt}, 32'd4);

      // PC wrap at the top of the address space
      flush_req = 1'b1;
      flush_pc  = 32'hFFFF_FFFF;
      step();
      flush_req = 1'b0;
      drive(2'd2, 32'h0000_8082, 1'b1);
      step();
      chk("wrap_pc0",    bus.out_pc, 32'hFFFF_FFFE);
      chk("wrap_instr0", bus.out_instr, 32'h0000_8082);
      drive(2'd2, 32'h0000_0001, 1'b1);
      step();
      chk("wrap_pc1", bus.out_pc, 32'h0000_0000);
      drive(2'd0, 32'h0, 1'b1);
      step();
      chk("drain_vld", {31'h0, bus.out_vld}, 32'h0);

      // Reset mid-operation drops the held instruction
      drive(2'd2, 32'h0000_4501, 1'b0);
      step();
      chk("pre_rst_pc", bus.out_pc, 32'h0000_0002);
      rst = 1'b1;
      settle();
      chk("mid_rst_pop", {31'h0, bus.ifq_pop}, 32'h0);
      step();
      chk("mid_rst_vld",   {31'h0, bus.out_vld}, 32'h0);
      chk("mid_rst_pc",    bus.out_pc, 32'h0000_0100);
      chk("mid_rst_stall", {16'h0, stall_cnt}, 32'h0);

      // An avail value of 3 behaves as 2
      rst = 1'b0;
      drive(2'd3, 32'h0010_0093, 1'b1);
      settle();
      chk("av3_pop", {31'h0, bus.ifq_pop}, 32'h1);
      step();
      chk("av3_instr", bus.out_instr, 32'h0010_0093);
      chk("av3_pc",    bus.out_pc, 32'h0000_0100);

      // Starvation counter saturates on the 4-bit instance
      rst2 = 1'b0;
      for (int i = 0; i < 14; i++) step();
      chk("sat_14", {28'h0, stall_cnt2}, 32'd14);
      for (int i = 0; i < 6; i++) step();
      chk("sat_max", {28'h0, stall_cnt2}, 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_align_stage.md
Name: instr_align_stage

Overview:
- Pipeline stage 0 of the core. Sits directly downstream of the instruction fetch queue inside the instruction bus interface and consumes its 16-bit-granular output.
- Classifies the head of the queue as an RVC (16-bit) or a full 32-bit instruction and pops the matching amount.
- Tracks the PC of each instruction and presents {instr, pc, rvc} to decode through a registered valid/ready handshake.
- Jumps flush the stage and reload the PC.

Parameters:
- RESET_PC, default `RESET_PC (from femto.vh), PC loaded at reset; bit 0 forced to 0.
- STALL_CNT_W, default 16, width of the saturating starvation counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- flush_req  input  1  jump/redirect; same signal as jmp_req into the bus interface
- flush_pc  input  32  target PC; bit 0 ignored
- ifq_avail  input  2  16-bit entries filled in the queue (0..2; value 3 treated as 2)
- ifq_data  input  32  queue head; halfword 0 in [15:0], halfword 1 in [31:16] (valid only when avail==2)
- ifq_pop  output  1  pop request this cycle (drives instr_req)
- ifq_pop_16bit  output  1  1 = pop one halfword, 0 = pop two (drives instr_size)
- out_vld  output  1  instruction valid to decode
- out_rdy  input  1  decode accepts
- out_instr  output  32  instruction; RVC is zero-extended in [31:16]
- out_pc  output  32  PC of out_instr
- out_rvc  output  1  1 = 16-bit instruction
- stall_cnt  output  STALL_CNT_W  saturating count of starved cycles

Behaviour:
- Reset (rst=1 at edge):
  - out_vld=0, out_instr=0, out_pc=RESET_PC&~1, out_rvc=0, stall_cnt=0.
  - Fetch PC register = RESET_PC&~1.
  - ifq_pop=0 while rst=1.
  - Reset mid-operation discards any held instruction; no pop occurs in that cycle.
- Slot free: slot_free = ~out_vld | out_rdy.
- Head classification: is_rvc = (ifq_data[1:0] != 2'b11).
- Fire conditions (combinational, only when ~rst & ~flush_req & slot_free):
  - avail>=1 & is_rvc -> fire16.
  - avail==2 & ~is_rvc -> fire32.
  - avail==1 & ~is_rvc -> wait: no pop; the halfword stays in the queue.
- Pop outputs:
  - ifq_pop = fire16 | fire32.
  - ifq_pop_16bit = is_rvc; don't-care when ifq_pop=0.
  - No combinational path from ifq_pop back to ifq_avail is assumed.
- On fire, next edge:
  - out_vld=1.
  - out_instr = fire16 ? {16'h0, ifq_data[15:0]} : ifq_data.
  - out_rvc = fire16; out_pc = fetch PC.
  - Fetch PC += 2 (fire16) or +4 (fire32), modulo 2^32 (0xFFFF_FFFE+2 -> 0x0000_0000).
- No fire but out_rdy & out_vld: out_vld <= 0.
- Hold: out_vld & ~out_rdy -> out_instr, out_pc and out_rvc are stable and out_vld stays 1.
- Throughput: one instruction per cycle when the queue keeps up. Latency is one cycle from queue head to out_vld.
- Flush (priority rst > flush_req > normal):
  - Next edge: out_vld=0, fetch PC = flush_pc&~1, no pop.
  - The queue is cleared by the same signal externally.
  - out_rdy in the flush cycle is ignored; the held instruction is dropped.
  - The first post-flush instruction can appear 2 cycles after flush_req at the earliest (queue refill is extra).
- Starvation counter:
  - Increments when ~rst & ~flush_req & slot_free and no fire occurs (avail==0, or avail==1 with a 32-bit head).
  - Saturates at all-ones; cleared only by rst.
- No state machine beyond the output register, fetch PC and counter. No misalignment traps; PC is always halfword-aligned.

Test Plan:
- Reset with RESET_PC=0x0000_0100 -> out_vld=0, out_pc=0x100, stall_cnt=0, ifq_pop=0.
- avail=2, data=0x0001_4501 (RVC head 0x4501), out_rdy=1 -> pop16; next cycle out_instr=0x0000_4501, out_rvc=1, out_pc=0x100; fetch PC becomes 0x102.
- avail=1, data[15:0]=0x0093 (32-bit head), held 3 cycles, then avail=2 with data=0x0010_0093 -> no pop for 3 cycles, stall_cnt=3; then pop32 with out_instr=0x0010_0093, out_rvc=0, out_pc=0x102, next PC 0x106.
- out_vld=1 with out_rdy=0 for 4 cycles while avail=2 -> ifq_pop=0 and outputs stable; out_rdy=1 -> accept and pop the next instruction in the same cycle (back-to-back).
- flush_req=1 with flush_pc=0x0000_2003 while out_vld=1 and avail=2 -> no pop; next cycle out_vld=0; first subsequent instruction has out_pc=0x2002.
- Fetch PC=0xFFFF_FFFE with an RVC fire -> out_pc=0xFFFF_FFFE, next PC 0x0000_0000. stall_cnt forced past 0xFFFF -> remains 0xFFFF.
